aes_decrypt_iterative: RTL and testbench
========================================

Name: aes_decrypt_iterative

Overview:
- AES-128 inverse cipher (FIPS-197 §5.3); the decrypt-side counterpart of the team's pipelined AES-128 encryptor `cipher_text_generation`.
- Accepts a ciphertext/key pair with a valid/ready handshake and returns plaintext after a fixed latency.
- Iterative architecture, one round per cycle, one block in flight.
- The core first runs the forward key schedule to round key 10. It then decrypts while stepping the key schedule backwards, so no round-key storage is needed.

Parameters:
- HOLD_OUTPUT, 1, 1 = plaintext holds its last result until the next completion; 0 = plaintext reads zero whenever valid_output is low.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- valid_in  input  1  ciphertext/key are valid this cycle.
- ready  output  1  core can accept a block this cycle.
- ciphertext  input  128  block to decrypt; byte 0 = bits [127:120], column-major state.
- key  input  128  cipher key (same key used to encrypt), same byte order.
- valid_output  output  1  one-cycle pulse: plaintext is valid.
- plaintext  output  128  decrypted block.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-high, named `reset`; evaluated only at the rising edge of clk.
- Reset values:
  - state = IDLE; ready = 1; valid_output = 0; plaintext = 0.
  - Internal state, key and round-counter registers = 0.
- Reset mid-operation: any in-flight block is discarded and no valid_output is produced for it. ready = 1 in the cycle after reset deasserts.
- FSM states: IDLE, EXPAND, ROUND, DONE.
- Acceptance: a block is accepted at edge E0, where valid_in && ready. valid_in while ready = 0 is ignored with no side effect.
- At E0:
  - state_reg <= ciphertext; key_reg <= key; rcon <= 0x01; cnt <= 1; FSM -> EXPAND.
- EXPAND, edges E1..E10:
  - key_reg <= forward_step(key_reg, rcon).
  - rcon <= xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1b,36.
  - At E10 key_reg = rk10 and state_reg <= state_reg ^ rk10 (initial AddRoundKey, using the combinational next key). cnt resets to 1; FSM -> ROUND.
- ROUND, edges E11..E20 (j = 1..10):
  - key_reg <= inverse_step(key_reg, rcon_j), where rcon_j = rcon for round 11-j. For words w0..w3: w3' = w3^w2, w2' = w2^w1, w1' = w1^w0, w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon_j.
  - state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), key_next)).
  - InvMixColumns is omitted at j = 10.
  - At E20 plaintext <= result; FSM -> DONE.
- DONE (one cycle):
  - valid_output = 1; ready = 1.
  - Back-to-back acceptance is allowed here and counts as E0 of the next block.
  - Next edge: FSM -> EXPAND if a block was accepted, else IDLE.
- Latency: valid_output is high in the cycle after E20, i.e. 20 clock edges after acceptance. Back-to-back throughput is 1 block per 21 cycles.
- ready = 1 only in IDLE and DONE.
- HOLD_OUTPUT = 0: plaintext is driven 0 whenever valid_output = 0.
- Width rules:
  - All GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1.
  - InvMixColumns coefficients 0e,0b,0d,09, built from chained xtime.
  - cnt is 4 bits and never exceeds 10.
  - key_reg after E20 equals the original key (self-check assertion).

Decomposition:
- Package aes_pkg holds:
  - FSM state enum; NR = 10.
  - SBOX and INV_SBOX 256x8 constant tables; RCON table.
  - Functions xtime, gmul, sub_word, rot_word, inv_shift_rows, inv_mix_columns.
- Sub-module aes_inv_round (combinational): inputs state, round_key, last_round; output next state. Datapath stays separate from the FSM.
- Forward and inverse key steps are package functions.

Test Plan:
- FIPS-197 App. B: ciphertext 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c -> plaintext 3243f6a8885a308d313198a2e0370734 with valid_output exactly 20 edges after accept.
- FIPS-197 App. C.1: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f -> plaintext 00112233445566778899aabbccddeeff.
- All zeros: ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e, key 0 -> plaintext 0. Issue this block in the DONE cycle of the previous one: ready = 1 there, accepted, and valid_output recurs 21 cycles after the prior pulse.
- Busy ignore: pulse valid_in with different data at E5 and E15 -> ready = 0, no effect, and the first result is unchanged.
- Reset mid-block: assert reset at E12 for one cycle -> no valid_output, plaintext = 0, ready = 1 in the next cycle; a fresh App. B block then decrypts correctly.
- Loopback: feed the encryptor's outputs for the App. B, all-zeros and C.1 vectors into this block -> recovered plaintext equals the encryptor's inputs.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared definitions for the iterative inverse cipher:
// FSM states, S-box tables, round constants, GF(2^8) helpers and key steps.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } aes_state_e;

   localparam int NR = 10;

   // Round constants for rounds 1..10 at index 0..9; upper entries are padding
   // so a 4-bit index can never fall outside the table.
   localparam logic [7:0] RCON [0:15] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
      8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) product as a shift-and-add chain of xtime.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? t : 8'h00);
         t = xtime(t);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Byte i of the state sits at bits [127-8i -: 8]; i = 4*column + row.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int i = 0; i < 16; i++) begin
         o[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // One step of the forward AES-128 key schedule: rk(n-1) -> rk(n).
   function automatic logic [127:0] forward_key_step(input logic [127:0] k, input logic [7:0] rcon);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rcon, 24'h000000};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0]  ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one forward step: rk(n) -> rk(n-1), with rcon belonging to round n.
   function automatic logic [127:0] inverse_key_step(input logic [127:0] k, input logic [7:0] rcon);
      logic [31:0] n0, n1, n2, n3;
      n3 = k[31:0]  ^ k[63:32];
      n2 = k[63:32] ^ k[95:64];
      n1 = k[95:64] ^ k[127:96];
      n0 = k[127:96] ^ sub_word(rot_word(n3)) ^ {rcon, 24'h000000};
      return {n0, n1, n2, n3};
   endfunction

endpackage

// File: rtl/aes_decrypt_iterative_chk.sv
// Property checker for the iterative decryptor: the reversed key schedule
// must land back on the accepted cipher key, and the round counter stays <= 10.
module aes_decrypt_iterative_chk (
   input logic         i_clk,
   input logic         i_reset,
   input logic         i_accept,
   input logic [127:0] i_key,
   input logic         i_final_edge,
   input logic [127:0] i_key_next,
   input logic [3:0]   i_cnt
);

   logic [127:0] r_key_cap;

   // Remember the cipher key of the block currently in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_key_cap <= 128'h0;
      end else if (i_accept) begin
         r_key_cap <= i_key;
      end else begin
         r_key_cap <= r_key_cap;
      end
   end

   a_key_restored: assert property (@(posedge i_clk) disable iff (i_reset)
      i_final_edge |-> (i_key_next == r_key_cap));

   a_cnt_range: assert property (@(posedge i_clk) disable iff (i_reset)
      i_cnt <= 4'd10);

endmodule

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns except on the final round.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_round_key,
   input  logic         i_last_round,
   output logic [127:0] o_state
);

   logic [127:0] w_added;

   assign w_added = inv_sub_bytes(inv_shift_rows(i_state)) ^ i_round_key;
   assign o_state = i_last_round ? w_added : inv_mix_columns(w_added);

endmodule

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryptor: one block in flight, one round per clock.
// Runs the forward key schedule up to rk10, then decrypts while stepping the
// schedule backwards so no round keys are stored.
module aes_decrypt_iterative
   import aes_pkg::*;
#(
   parameter int HOLD_OUTPUT = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_in,
   output logic         ready,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic         valid_output,
   output logic [127:0] plaintext
);

   aes_state_e   r_fsm;
   aes_state_e   w_fsm_next;
   logic [127:0] r_state;
   logic [127:0] r_key;
   logic [127:0] r_plaintext;
   logic [7:0]   r_rcon;
   logic [3:0]   r_cnt;
   logic         r_valid_out;

   logic         w_accept;
   logic         w_last;
   logic [7:0]   w_rcon_inv;
   logic [127:0] w_key_fwd;
   logic [127:0] w_key_inv;
   logic [127:0] w_round_out;
   logic         w_final_edge;

   assign ready        = (r_fsm == IDLE) || (r_fsm == DONE);
   assign w_accept     = valid_in && ready;
   assign w_last       = (r_cnt == 4'd10);
   // During ROUND step j = r_cnt undoes key-schedule round 11-j.
   assign w_rcon_inv   = RCON[4'd10 - r_cnt];
   assign w_key_fwd    = forward_key_step(r_key, r_rcon);
   assign w_key_inv    = inverse_key_step(r_key, w_rcon_inv);
   assign w_final_edge = (r_fsm == ROUND) && w_last;

   aes_inv_round u_round (
      .i_state     (r_state),
      .i_round_key (w_key_inv),
      .i_last_round(w_last),
      .o_state     (w_round_out)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   // Next-state decode; a new block may be taken in IDLE or in the DONE cycle.
   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         IDLE: begin
            if (valid_in) w_fsm_next = EXPAND;
            else          w_fsm_next = IDLE;
         end
         EXPAND: begin
            if (w_last) w_fsm_next = ROUND;
            else        w_fsm_next = EXPAND;
         end
         ROUND: begin
            if (w_last) w_fsm_next = DONE;
            else        w_fsm_next = ROUND;
         end
         DONE: begin
            if (valid_in) w_fsm_next = EXPAND;
            else          w_fsm_next = IDLE;
         end
         default: w_fsm_next = IDLE;
      endcase
   end

   // Datapath: load, forward key expansion, then inverse rounds with key rewind.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= 128'h0;
         r_key       <= 128'h0;
         r_plaintext <= 128'h0;
         r_rcon      <= 8'h00;
         r_cnt       <= 4'd0;
         r_valid_out <= 1'b0;
      end else begin
         r_valid_out <= 1'b0;
         case (r_fsm)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_state <= ciphertext;
                  r_key   <= key;
                  r_rcon  <= 8'h01;
                  r_cnt   <= 4'd1;
               end
            end
            EXPAND: begin
               r_key  <= w_key_fwd;
               r_rcon <= xtime(r_rcon);
               if (w_last) begin
                  // Initial AddRoundKey uses rk10 as it is being produced.
                  r_state <= r_state ^ w_key_fwd;
                  r_cnt   <= 4'd1;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ROUND: begin
               r_key   <= w_key_inv;
               r_state <= w_round_out;
               if (w_last) begin
                  r_plaintext <= w_round_out;
                  r_valid_out <= 1'b1;
                  r_cnt       <= 4'd0;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: begin
               r_cnt <= 4'd0;
            end
         endcase
      end
   end

   assign valid_output = r_valid_out;
   assign plaintext    = ((HOLD_OUTPUT != 0) || r_valid_out) ? r_plaintext : 128'h0;

   aes_decrypt_iterative_chk u_chk (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_accept    (w_accept),
      .i_key       (key),
      .i_final_edge(w_final_edge),
      .i_key_next  (w_key_inv),
      .i_cnt       (r_cnt)
   );

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Directed testbench for aes_decrypt_iterative using FIPS-197 vectors.
module tb_aes_decrypt_iterative;

   logic         clk;
   logic         reset;
   logic         valid_in;
   logic         ready;
   logic [127:0] ciphertext;
   logic [127:0] key;
   logic         valid_output;
   logic [127:0] plaintext;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] ZERO  = 128'h0;

   aes_decrypt_iterative #(.HOLD_OUTPUT(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_in    (valid_in),
      .ready       (ready),
      .ciphertext  (ciphertext),
      .key         (key),
      .valid_output(valid_output),
      .plaintext   (plaintext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one block for a single edge (acceptance edge E0 when ready).
   task automatic accept_block(input logic [127:0] ct, input logic [127:0] k);
      valid_in   = 1'b1;
      ciphertext = ct;
      key        = k;
      tick();
      valid_in   = 1'b0;
      ciphertext = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      key        = 128'hcafef00d_cafef00d_cafef00d_cafef00d;
   endtask

   // Count edges after E0 until valid_output; -1 when the bound expires.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (valid_output === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks++;
      if (ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ready: got %b expected 1", ready);
      end
      n_checks++;
      if (valid_output !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_valid: got %b expected 0", valid_output);
      end
      n_checks++;
      if (plaintext !== ZERO) begin
         n_errors++;
         $display("FAIL reset_plaintext: got %h expected 0", plaintext);
      end
   endtask

   task automatic test_app_b();
      int lat;
      accept_block(CT_B, KEY_B);
      n_checks++;
      if (ready !== 1'b0) begin
         n_errors++;
         $display("FAIL app_b_busy_ready: got %b expected 0", ready);
      end
      wait_done(lat);
      n_checks++;
      if (lat != 20) begin
         n_errors++;
         $display("FAIL app_b_latency: got %0d expected 20", lat);
      end
      n_checks++;
      if (plaintext !== PT_B) begin
         n_errors++;
         $display("FAIL app_b_plaintext: got %h expected %h", plaintext, PT_B);
      end
      n_checks++;
      if (ready !== 1'b1) begin
         n_errors++;
         $display("FAIL app_b_done_ready: got %b expected 1", ready);
      end
      tick();
      n_checks++;
      if (valid_output !== 1'b0) begin
         n_errors++;
         $display("FAIL app_b_pulse_width: got %b expected 0", valid_output);
      end
      n_checks++;
      if (plaintext !== PT_B) begin
         n_errors++;
         $display("FAIL app_b_hold: got %h expected %h", plaintext, PT_B);
      end
   endtask

   task automatic test_app_c1();
      int lat;
      accept_block(CT_C, KEY_C);
      wait_done(lat);
      n_checks++;
      if (lat != 20) begin
         n_errors++;
         $display("FAIL c1_latency: got %0d expected 20", lat);
      end
      n_checks++;
      if (plaintext !== PT_C) begin
         n_errors++;
         $display("FAIL c1_plaintext: got %h expected %h", plaintext, PT_C);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      int lat2;
      accept_block(CT_B, KEY_B);
      wait_done(lat);
      n_checks++;
      if (plaintext !== PT_B) begin
         n_errors++;
         $display("FAIL b2b_first_plaintext: got %h expected %h", plaintext, PT_B);
      end
      n_checks++;
      if (ready !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_done_ready: got %b expected 1", ready);
      end
      // Issue the all-zeros block in the DONE cycle.
      accept_block(CT_Z, ZERO);
      wait_done(lat2);
      n_checks++;
      if (lat2 + 1 != 21) begin
         n_errors++;
         $display("FAIL b2b_pulse_spacing: got %0d expected 21", lat2 + 1);
      end
      n_checks++;
      if (plaintext !== ZERO) begin
         n_errors++;
         $display("FAIL b2b_zero_plaintext: got %h expected %h", plaintext, ZERO);
      end
      tick();
   endtask

   task automatic test_busy_ignore();
      int lat;
      accept_block(CT_C, KEY_C);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5 || i == 15) begin
            valid_in   = 1'b1;
            ciphertext = CT_B;
            key        = KEY_B;
            n_checks++;
            if (ready !== 1'b0) begin
               n_errors++;
               $display("FAIL busy_ready_e%0d: got %b expected 0", i, ready);
            end
         end
         tick();
         valid_in = 1'b0;
         if (valid_output === 1'b1) begin
            lat = i;
            break;
         end
      end
      n_checks++;
      if (lat != 20) begin
         n_errors++;
         $display("FAIL busy_latency: got %0d expected 20", lat);
      end
      n_checks++;
      if (plaintext !== PT_C) begin
         n_errors++;
         $display("FAIL busy_plaintext: got %h expected %h", plaintext, PT_C);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat;
      int pulses;
      accept_block(CT_B, KEY_B);
      for (int i = 1; i <= 11; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (ready !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_mid_ready: got %b expected 1", ready);
      end
      n_checks++;
      if (plaintext !== ZERO) begin
         n_errors++;
         $display("FAIL rst_mid_plaintext: got %h expected 0", plaintext);
      end
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (valid_output === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_errors++;
         $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", pulses);
      end
      accept_block(CT_B, KEY_B);
      wait_done(lat);
      n_checks++;
      if (lat != 20) begin
         n_errors++;
         $display("FAIL rst_mid_latency: got %0d expected 20", lat);
      end
      n_checks++;
      if (plaintext !== PT_B) begin
         n_errors++;
         $display("FAIL rst_mid_plaintext_after: got %h expected %h", plaintext, PT_B);
      end
      tick();
   endtask

   task automatic test_loopback();
      logic [127:0] lb_ct  [3];
      logic [127:0] lb_key [3];
      logic [127:0] lb_pt  [3];
      int lat;
      lb_ct[0] = CT_B; lb_key[0] = KEY_B; lb_pt[0] = PT_B;
      lb_ct[1] = CT_Z; lb_key[1] = ZERO;  lb_pt[1] = ZERO;
      lb_ct[2] = CT_C; lb_key[2] = KEY_C; lb_pt[2] = PT_C;
      for (int v = 0; v < 3; v++) begin
         accept_block(lb_ct[v], lb_key[v]);
         wait_done(lat);
         n_checks++;
         if (lat != 20 || plaintext !== lb_pt[v]) begin
            n_errors++;
            $display("FAIL loopback_%0d: got lat %0d pt %h expected lat 20 pt %h",
                     v, lat, plaintext, lb_pt[v]);
         end
      end
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      valid_in   = 1'b0;
      ciphertext = 128'h0;
      key        = 128'h0;
      test_reset();
      test_app_b();
      test_app_c1();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
